// File: rtl/videocard_host_pkg.sv
// Shared encodings for the videocard host master: command opcodes, FSM states
// and control-port register map.
package videocard_host_pkg;

    localparam logic [1:0] OP_WRITE_BLK = 2'd0;
    localparam logic [1:0] OP_READ_BLK  = 2'd1;
    localparam logic [1:0] OP_START     = 2'd2;
    localparam logic [1:0] OP_WAIT_DONE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_DRAIN,
        ST_START,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_FIN
    } state_e;

    localparam int CTRL_START     = 0;
    localparam int CTRL_ACK       = 1;
    localparam int CTRL_CORE_BASE = 2;

endpackage

// File: rtl/host_rd_fifo.sv
// Small synchronous FIFO that buffers memory read data for the outgoing read stream.
module host_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/videocard_host_master.sv
// HPS-side initiator: runs one host command at a time against the videocard
// memory and control ports.
//   state        | meaning
//   ST_IDLE      | waiting for a command
//   ST_WR        | one memory write per accepted stream word
//   ST_RD        | issuing memory reads while the FIFO has room
//   ST_RD_DRAIN  | waiting for in-flight reads and FIFO to empty
//   ST_START     | control writes: start, ack, core enables
//   ST_POLL_RD   | status read strobe
//   ST_POLL_WAIT | waiting for status data
//   ST_FIN       | done pulse, back to idle
module videocard_host_master
    import videocard_host_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDR_W      = 17,
    parameter int CTRL_ADDR_W = 3,
    parameter int CORES       = 4,
    parameter int RD_LAT      = 1,
    parameter int STATUS_ADDR = 1,
    parameter int TIMEOUT     = 65535
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [ADDR_W-1:0]      cmd_len,
    input  logic [CORES-1:0]       cmd_mask,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [ADDR_W-1:0]      address,
    output logic [WIDTH-1:0]       data_in,
    input  logic [WIDTH-1:0]       data_out,
    output logic                   write,
    output logic                   read,
    output logic [CTRL_ADDR_W-1:0] address_control,
    output logic [WIDTH-1:0]       data_in_control,
    input  logic [WIDTH-1:0]       data_out_control,
    output logic                   write_control,
    output logic                   read_control,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int FIFO_DEPTH = RD_LAT + 1;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int PCW        = $clog2(TIMEOUT + 1);
    localparam int WW         = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

    state_e                 state_q;
    logic [ADDR_W-1:0]      addr_q, len_q, idx_q, idx_nx;
    logic [CORES-1:0]       mask_q;
    logic [PCW-1:0]         poll_q;
    logic [WW-1:0]          wait_q;
    logic                   err_q, done_q;
    logic                   write_q, read_q, write_control_q, read_control_q;
    logic [ADDR_W-1:0]      address_q;
    logic [WIDTH-1:0]       data_in_q, data_in_control_q;
    logic [CTRL_ADDR_W-1:0] address_control_q;
    logic [RD_LAT-1:0]      rd_pipe_q;

    logic [CW-1:0]          fifo_count;
    logic                   fifo_empty;
    int unsigned            inflight;
    logic                   issue_ok;
    logic                   status_unused;

    assign idx_nx        = idx_q + ADDR_W'(1);
    assign status_unused = ^data_out_control[WIDTH-1:1];

    // Reads still owed to the FIFO: the strobe on the bus plus the latency pipe.
    always_comb begin
        inflight = 32'(read_q);
        for (int k = 0; k < RD_LAT; k++) inflight = inflight + 32'(rd_pipe_q[k]);
    end

    assign issue_ok = (32'(fifo_count) + inflight) < 32'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q[0] <= read_q;
            for (int k = 1; k < RD_LAT; k++) rd_pipe_q[k] <= rd_pipe_q[k-1];
        end
    end

    host_rd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (rd_pipe_q[RD_LAT-1]),
        .push_data_i (data_out),
        .pop_i       (rd_valid && rd_ready),
        .pop_data_o  (rd_data),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            addr_q            <= '0;
            len_q             <= '0;
            idx_q             <= '0;
            mask_q            <= '0;
            poll_q            <= '0;
            wait_q            <= '0;
            err_q             <= 1'b0;
            done_q            <= 1'b0;
            write_q           <= 1'b0;
            read_q            <= 1'b0;
            write_control_q   <= 1'b0;
            read_control_q    <= 1'b0;
            address_q         <= '0;
            data_in_q         <= '0;
            address_control_q <= '0;
            data_in_control_q <= '0;
        end else begin
            done_q          <= 1'b0;
            write_q         <= 1'b0;
            read_q          <= 1'b0;
            write_control_q <= 1'b0;
            read_control_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        mask_q <= cmd_mask;
                        idx_q  <= '0;
                        poll_q <= '0;
                        err_q  <= 1'b0;
                        case (cmd_op)
                            OP_WRITE_BLK, OP_READ_BLK: begin
                                if (cmd_len == '0) begin
                                    state_q <= ST_FIN;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= (cmd_op == OP_WRITE_BLK) ? ST_WR : ST_RD;
                                end
                            end
                            OP_START: state_q <= ST_START;
                            default:  state_q <= ST_POLL_RD;
                        endcase
                    end
                end
                ST_WR: begin
                    if (wr_valid) begin
                        write_q   <= 1'b1;
                        address_q <= addr_q + idx_q;
                        data_in_q <= wr_data;
                        idx_q     <= idx_nx;
                        if (idx_nx == len_q) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (issue_ok) begin
                        read_q    <= 1'b1;
                        address_q <= addr_q + idx_q;
                        idx_q     <= idx_nx;
                        if (idx_nx == len_q) state_q <= ST_RD_DRAIN;
                    end
                end
                ST_RD_DRAIN: begin
                    if (inflight == 0 && fifo_empty) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    write_control_q <= 1'b1;
                    if (idx_q == ADDR_W'(CTRL_START)) begin
                        address_control_q <= CTRL_ADDR_W'(CTRL_START);
                        data_in_control_q <= WIDTH'(1);
                    end else if (idx_q == ADDR_W'(CTRL_ACK)) begin
                        address_control_q <= CTRL_ADDR_W'(CTRL_ACK);
                        data_in_control_q <= '0;
                    end else begin
                        // Mask is shifted so bit 0 always belongs to the core being written.
                        address_control_q <= idx_q[CTRL_ADDR_W-1:0];
                        data_in_control_q <= WIDTH'(mask_q[0]);
                        mask_q            <= mask_q >> 1;
                    end
                    idx_q <= idx_nx;
                    if (idx_q == ADDR_W'(CTRL_CORE_BASE + CORES - 1)) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end
                end
                ST_POLL_RD: begin
                    read_control_q    <= 1'b1;
                    address_control_q <= CTRL_ADDR_W'(STATUS_ADDR);
                    wait_q            <= WW'(RD_LAT);
                    state_q           <= ST_POLL_WAIT;
                end
                ST_POLL_WAIT: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - WW'(1);
                    end else if (data_out_control[0]) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else if (poll_q == PCW'(TIMEOUT)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        poll_q  <= poll_q + PCW'(1);
                        state_q <= ST_POLL_RD;
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign wr_ready        = (state_q == ST_WR) && wr_valid;
    assign rd_valid        = !fifo_empty;
    assign address         = address_q;
    assign data_in         = data_in_q;
    assign write           = write_q;
    assign read            = read_q;
    assign address_control = address_control_q;
    assign data_in_control = data_in_control_q;
    assign write_control   = write_control_q;
    assign read_control    = read_control_q;
    assign done            = done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_videocard_host_master.sv
// Directed bench for videocard_host_master with memory and status-register models.
module tb_videocard_host_master;
    import videocard_host_pkg::*;

    localparam int TIMEOUT = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [16:0] cmd_addr = '0;
    logic [16:0] cmd_len = '0;
    logic [3:0]  cmd_mask = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic [16:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out = '0;
    logic        write, read;
    logic [2:0]  address_control;
    logic [31:0] data_in_control;
    logic [31:0] data_out_control = '0;
    logic        write_control, read_control;
    logic        busy, done, err;

    always #5 clk = ~clk;

    videocard_host_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_mask(cmd_mask),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .address(address), .data_in(data_in), .data_out(data_out),
        .write(write), .read(read),
        .address_control(address_control), .data_in_control(data_in_control),
        .data_out_control(data_out_control),
        .write_control(write_control), .read_control(read_control),
        .busy(busy), .done(done), .err(err)
    );

    function automatic logic [31:0] mem_val(input logic [16:0] a);
        return 32'hA500_0000 + 32'(a) * 32'd7;
    endfunction

    // Memory and status register, both with one cycle of read latency.
    int creads = 0;
    int poll_lim = 0;
    always @(posedge clk) begin
        if (read) data_out <= mem_val(address);
        if (read_control) begin
            data_out_control <= (creads >= poll_lim) ? 32'd1 : 32'd0;
            creads <= creads + 1;
        end
    end

    logic [63:0] wlog[$];
    logic [63:0] clog[$];
    logic [31:0] rlog[$];
    logic [31:0] rx[$];
    int wcyc[$];
    int ccyc[$];
    int cyc = 0, npoll = 0, bad_poll = 0, ndone = 0, nwr_ready = 0, excl_bad = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (write) begin
            wlog.push_back({15'd0, address, data_in});
            wcyc.push_back(cyc);
        end
        if (read) rlog.push_back(32'(address));
        if (write_control) begin
            clog.push_back({29'd0, address_control, data_in_control});
            ccyc.push_back(cyc);
        end
        if (read_control) begin
            npoll <= npoll + 1;
            if (address_control != 3'd1) bad_poll <= bad_poll + 1;
        end
        if (done) ndone <= ndone + 1;
        if (rd_valid && rd_ready) rx.push_back(rd_data);
        if (wr_ready) nwr_ready <= nwr_ready + 1;
        if ((write && read) || (write_control && read_control) ||
            ((write || read) && (write_control || read_control)))
            excl_bad <= excl_bad + 1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [16:0] a,
                            input logic [16:0] l, input logic [3:0] m);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("cmd_ready", cmd_ready, 1);
        cmd_op = op; cmd_addr = a; cmd_len = l; cmd_mask = m;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int start);
        int t = 0;
        while (ndone == start && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_done_pulses"}, 64'(ndone - start), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] wvals[3]   = '{32'd1, 32'd12, 32'd7};
    logic [16:0] raddrs[3]  = '{17'd131070, 17'd131071, 17'd0};
    logic [31:0] st_exp[6]  = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};

    initial begin
        int d0, w0, r0, x0, c0, p0, t;

        reset_n = 1'b0;
        #2;
        check_eq("rst_write", write, 0);
        check_eq("rst_read", read, 0);
        check_eq("rst_write_control", write_control, 0);
        check_eq("rst_read_control", read_control, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_address", address, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // Stream words offered while idle must be ignored.
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = 32'd99;
        repeat (3) @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check_eq("idle_wr_ready_count", nwr_ready, 0);
        check_eq("idle_write_count", wlog.size(), 0);

        // WRITE_BLK with a gapped stream
        d0 = ndone; w0 = wlog.size();
        send_cmd(OP_WRITE_BLK, 17'd0, 17'd3, 4'd0);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = wvals[i];
            @(posedge clk); #1;
            wr_valid = 1'b0;
            @(posedge clk); #1;
        end
        wait_done("wr", d0);
        check_eq("wr_count", wlog.size() - w0, 3);
        for (int i = 0; i < 3; i++)
            check_eq("wr_beat", (w0 + i < wlog.size()) ? wlog[w0+i] : 64'bx,
                     {32'(i), wvals[i]});
        for (int i = 1; i < 3; i++)
            if (w0 + i < wcyc.size())
                check_eq("wr_gap", 64'(wcyc[w0+i] - wcyc[w0+i-1]), 2);

        // READ_BLK across the address wrap with a stalled consumer
        d0 = ndone; r0 = rlog.size(); x0 = rx.size();
        rd_ready = 1'b1;
        send_cmd(OP_READ_BLK, 17'd131070, 17'd3, 4'd0);
        t = 0;
        while (rx.size() - x0 < 1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        rd_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rd_hold_valid", rd_valid, 1);
        check_eq("rd_hold_count", rx.size() - x0, 1);
        rd_ready = 1'b1;
        wait_done("rd", d0);
        check_eq("rd_strobe_count", rlog.size() - r0, 3);
        check_eq("rd_word_count", rx.size() - x0, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("rd_addr", (r0 + i < rlog.size()) ? rlog[r0+i] : 32'bx, 32'(raddrs[i]));
            check_eq("rd_data", (x0 + i < rx.size()) ? rx[x0+i] : 32'bx, mem_val(raddrs[i]));
        end
        check_eq("rd_valid_after", rd_valid, 0);

        // START with mask 0101
        d0 = ndone; c0 = clog.size();
        send_cmd(OP_START, 17'd0, 17'd0, 4'b0101);
        wait_done("start", d0);
        check_eq("start_count", clog.size() - c0, 6);
        for (int i = 0; i < 6; i++)
            check_eq("start_write", (c0 + i < clog.size()) ? clog[c0+i] : 64'bx,
                     {32'(i), st_exp[i]});
        if (c0 + 5 < ccyc.size())
            check_eq("start_consecutive", 64'(ccyc[c0+5] - ccyc[c0]), 5);

        // WAIT_DONE: ten busy polls then done
        d0 = ndone; p0 = npoll;
        poll_lim = creads + 10;
        send_cmd(OP_WAIT_DONE, 17'd0, 17'd0, 4'd0);
        wait_done("poll", d0);
        check_eq("poll_count", npoll - p0, 11);
        check_eq("poll_err", err, 0);

        // WAIT_DONE with the status stuck at 0
        d0 = ndone; p0 = npoll;
        poll_lim = creads + 100000;
        send_cmd(OP_WAIT_DONE, 17'd0, 17'd0, 4'd0);
        wait_done("timeout", d0);
        check_eq("timeout_poll_count", npoll - p0, TIMEOUT + 1);
        check_eq("timeout_err", err, 1);

        // Next command clears err; len=0 read does no bus activity
        d0 = ndone; r0 = rlog.size();
        send_cmd(OP_READ_BLK, 17'd5, 17'd0, 4'd0);
        check_eq("err_cleared", err, 0);
        wait_done("rd_len0", d0);
        check_eq("rd_len0_strobes", rlog.size() - r0, 0);
        check_eq("poll_address", bad_poll, 0);

        // Reset in the middle of a stalled READ_BLK
        rd_ready = 1'b0;
        send_cmd(OP_READ_BLK, 17'd100, 17'd8, 4'd0);
        repeat (6) @(posedge clk);
        #1;
        check_eq("pre_reset_rd_valid", rd_valid, 1);
        check_eq("pre_reset_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("reset_read", read, 0);
        check_eq("reset_rd_valid", rd_valid, 0);
        check_eq("reset_busy", busy, 0);
        r0 = rlog.size();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("post_reset_cmd_ready", cmd_ready, 1);
        check_eq("post_reset_no_reads", rlog.size() - r0, 0);

        d0 = ndone; w0 = wlog.size(); r0 = rlog.size(); c0 = clog.size(); p0 = npoll;
        send_cmd(OP_WRITE_BLK, 17'd40, 17'd0, 4'd0);
        wait_done("wr_len0", d0);
        check_eq("len0_bus_strobes",
                 64'((wlog.size() - w0) + (rlog.size() - r0) + (clog.size() - c0) + (npoll - p0)), 0);

        check_eq("strobe_exclusion", excl_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
